// File: rtl/iter_div_if.sv
// ---------------------------------------------------------------------------
// iter_div_if
//   Operand/result bundle between the execute stage and the iterative divider.
//
//   Handshake: the master raises start_i with operands valid. The divider
//   accepts them only while idle, and only when annul_i is low. It then holds
//   busy_o while iterating. It pulses ready_o for one cycle when result_o and
//   dz_o become valid. Those two outputs then hold until the next completion.
//   annul_i abandons an operation in flight.
//
//   Signals (WIDTH = operand width):
//     signed_div_i  1         two's-complement operands when 1
//     opdata1_i     WIDTH     dividend
//     opdata2_i     WIDTH     divisor
//     start_i       1         request
//     annul_i       1         abort / block acceptance
//     result_o      2*WIDTH   {remainder, quotient}
//     ready_o       1         completion pulse
//     busy_o        1         iterating
//     dz_o          1         divide-by-zero flag for result_o
// ---------------------------------------------------------------------------
interface iter_div_if #(
    parameter int WIDTH = 32
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;
    logic                 dz_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o, dz_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o, dz_o
    );
endinterface

// File: rtl/iter_div.sv
// ---------------------------------------------------------------------------
// iter_div
//   Iterative restoring divider. It produces signed or unsigned quotient and
//   remainder, and it performs BITS_PER_CYCLE quotient bits per clock.
//
//   Parameters:
//     WIDTH           operand width, a multiple of BITS_PER_CYCLE
//     BITS_PER_CYCLE  restoring steps per clock (1, 2 or 4)
//
//   Ports:
//     clk          clock, rising edge
//     rst          asynchronous active-low reset
//     bus          iter_div_if slave (operands, start/annul, result flags)
//     dbg_state_o  current FSM state (IDLE=0, BUSY=1, DONE=2)
//
//   Latency: the start is accepted at edge k. busy_o is high for cycles
//   k+1..k+N, where N = WIDTH/BITS_PER_CYCLE. ready_o is high in the cycle
//   after edge k+N. A zero divisor skips BUSY, so ready_o follows edge k.
// ---------------------------------------------------------------------------
module iter_div #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    iter_div_if.slave   bus,
    output logic [1:0]  dbg_state_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_STEP = CW'(BITS_PER_CYCLE);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [CW-1:0]        cnt_q,     cnt_d;
    logic [WIDTH-1:0]     rem_q,     rem_d;      // partial remainder
    logic [WIDTH-1:0]     quo_q,     quo_d;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]     dvs_q,     dvs_d;      // |divisor|
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q,  result_d;
    logic                 ready_q,   ready_d;
    logic                 busy_q,    busy_d;
    logic                 dz_q,      dz_d;

    // Modulo-2^WIDTH negation. MIN maps onto itself, so MIN / -1 needs no trap.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    // Operand magnitudes. Signs only count for signed division.
    logic             op1_neg, op2_neg;
    logic [WIDTH-1:0] op1_abs, op2_abs;

    always_comb begin
        op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
        op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
        op1_abs = op1_neg ? negate(bus.opdata1_i) : bus.opdata1_i;
        op2_abs = op2_neg ? negate(bus.opdata2_i) : bus.opdata2_i;
    end

    // One clock's worth of restoring steps, MSB first. The shifted remainder
    // can need WIDTH+1 bits before the compare. After the subtract it is
    // again below the divisor.
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    always_comb begin
        shifted  = '0;
        step_rem = rem_q;
        step_quo = quo_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            shifted  = {step_rem, step_quo[WIDTH-1]};
            step_quo = {step_quo[WIDTH-2:0], 1'b0};
            if (shifted >= {1'b0, dvs_q}) begin
                shifted     = shifted - {1'b0, dvs_q};
                step_quo[0] = 1'b1;
            end
            step_rem = shifted[WIDTH-1:0];
        end
    end

    logic [CW-1:0] cnt_next;
    assign cnt_next = cnt_q + CNT_STEP;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        dz_d      = dz_q;
        ready_d   = 1'b0;
        busy_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        // The raw dividend goes to HI and an all-ones quotient to LO.
                        result_d = {bus.opdata1_i, {WIDTH{1'b1}}};
                        dz_d     = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        quo_d     = op1_abs;
                        dvs_d     = op2_abs;
                        neg_quo_d = op1_neg ^ op2_neg;
                        neg_rem_d = op1_neg;
                        cnt_d     = '0;
                        rem_d     = '0;
                        state_d   = S_BUSY;
                    end
                end
            end

            S_BUSY: begin
                if (bus.annul_i) begin
                    // Abandon the operation. The last result and flag stay visible.
                    state_d = S_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_next;
                    if (cnt_next == CNT_LAST) begin
                        result_d = {neg_rem_q ? negate(step_rem) : step_rem,
                                    neg_quo_q ? negate(step_quo) : step_quo};
                        dz_d     = 1'b0;
                        state_d  = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Both flags are registered copies of the state being entered.
        busy_d  = (state_d == S_BUSY);
        ready_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    assign bus.busy_o   = busy_q;
    assign bus.dz_o     = dz_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_iter_div.sv
module tb_iter_div;

    logic clk;
    logic rst;
    logic [1:0] st32, st16;

    iter_div_if #(.WIDTH(32)) bus32 ();
    iter_div_if #(.WIDTH(16)) bus16 ();

    iter_div #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut32 (
        .clk(clk), .rst(rst), .bus(bus32), .dbg_state_o(st32)
    );
    iter_div #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16), .dbg_state_o(st16)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    // Drive one 32-bit operation and wait for ready_o, with a bounded wait.
    // The operands are scrambled once the start is accepted.
    task automatic run32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output logic dz,
                         output int lat, output int bsy, output logic got);
        @(negedge clk);
        bus32.signed_div_i = sgn;
        bus32.opdata1_i    = a;
        bus32.opdata2_i    = b;
        bus32.start_i      = 1'b1;
        lat = 0; bsy = 0; got = 1'b0; res = '0; dz = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            if (lat == 0) begin
                bus32.start_i      = 1'b0;
                bus32.signed_div_i = ~sgn;
                bus32.opdata1_i    = $urandom;
                bus32.opdata2_i    = $urandom;
            end
            lat++;
            if (bus32.busy_o) bsy++;
            if (bus32.ready_o) begin
                got = 1'b1;
                res = bus32.result_o;
                dz  = bus32.dz_o;
            end
        end
        chk("ready32_seen", 64'(got), 64'd1);
    endtask

    task automatic run16(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] res, output logic dz,
                         output int lat, output logic got);
        @(negedge clk);
        bus16.signed_div_i = sgn;
        bus16.opdata1_i    = a;
        bus16.opdata2_i    = b;
        bus16.start_i      = 1'b1;
        lat = 0; got = 1'b0; res = '0; dz = 1'b0;
        while (!got && lat < 50) begin
            @(negedge clk);
            if (lat == 0) begin
                bus16.start_i   = 1'b0;
                bus16.opdata1_i = 16'($urandom);
                bus16.opdata2_i = 16'($urandom);
            end
            lat++;
            if (bus16.ready_o) begin
                got = 1'b1;
                res = bus16.result_o;
                dz  = bus16.dz_o;
            end
        end
        chk("ready16_seen", 64'(got), 64'd1);
    endtask

    // The reference model works in 32-bit int, so MIN / -1 cannot overflow.
    function automatic logic [32:0] model16(input logic sgn, input logic [15:0] a, input logic [15:0] b);
        int x, y, q, r;
        if (b == 16'd0) return {1'b1, a, 16'hFFFF};
        if (sgn) begin
            x = int'($signed(a));
            y = int'($signed(b));
        end else begin
            x = int'({16'd0, a});
            y = int'({16'd0, b});
        end
        q = x / y;
        r = x % y;
        return {1'b0, r[15:0], q[15:0]};
    endfunction

    // Start an operation, then annul it in the BUSY cycle where busy_o has
    // been seen n times. Nothing must complete, and the old result must hold.
    task automatic start_and_annul(input logic [31:0] a, input logic [31:0] b, input int n,
                                   input logic [63:0] old_res, input string tag);
        int bsy, k;
        logic seen;
        @(negedge clk);
        bus32.signed_div_i = 1'b0;
        bus32.opdata1_i    = a;
        bus32.opdata2_i    = b;
        bus32.start_i      = 1'b1;
        bsy = 0; k = 0; seen = 1'b0;
        while (bsy < n && k < 100) begin
            @(negedge clk);
            if (k == 0) bus32.start_i = 1'b0;
            k++;
            if (bus32.busy_o) bsy++;
            if (bus32.ready_o) seen = 1'b1;
        end
        chk({tag, "_busy_reached"}, 64'(bsy), 64'(n));
        bus32.annul_i = 1'b1;
        @(negedge clk);
        bus32.annul_i = 1'b0;
        if (bus32.ready_o) seen = 1'b1;
        chk({tag, "_busy_low"}, 64'(bus32.busy_o), 64'd0);
        repeat (3) begin
            @(negedge clk);
            if (bus32.ready_o) seen = 1'b1;
        end
        chk({tag, "_no_ready"}, 64'(seen), 64'd0);
        chk({tag, "_result_held"}, bus32.result_o, old_res);
        chk({tag, "_dz_held"}, 64'(bus32.dz_o), 64'd0);
    endtask

    logic [63:0] res;
    logic [31:0] res16;
    logic        dz, got;
    int          lat, bsy;

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'h2,        32'hE},        1'b0, 33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 33};
        vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0,        32'h80000000}, 1'b0, 33};
        vecs[3]  = '{1'b0, 32'd5,          32'd0,          {32'h5,        32'hFFFFFFFF}, 1'b1, 1};
        vecs[4]  = '{1'b1, 32'd5,          32'd0,          {32'h5,        32'hFFFFFFFF}, 1'b1, 1};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'h0,        32'hFFFFFFFF}, 1'b0, 33};
        vecs[6]  = '{1'b0, 32'd7,          32'd100,        {32'h7,        32'h0},        1'b0, 33};
        vecs[7]  = '{1'b1, 32'd7,          32'hFFFFFFFD,   {32'h1,        32'hFFFFFFFE}, 1'b0, 33};
        vecs[8]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'h0},        1'b0, 33};
        vecs[9]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'hE},        1'b0, 33};
        vecs[10] = '{1'b1, 32'd0,          32'd5,          {32'h0,        32'h0},        1'b0, 33};
        vecs[11] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'h0,        32'h1},        1'b0, 33};

        bus32.signed_div_i = 1'b0; bus32.opdata1_i = '0; bus32.opdata2_i = '0;
        bus32.start_i = 1'b0; bus32.annul_i = 1'b0;
        bus16.signed_div_i = 1'b0; bus16.opdata1_i = '0; bus16.opdata2_i = '0;
        bus16.start_i = 1'b0; bus16.annul_i = 1'b0;

        // Reset state.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_result", bus32.result_o, 64'd0);
        chk("rst_ready",  64'(bus32.ready_o), 64'd0);
        chk("rst_busy",   64'(bus32.busy_o), 64'd0);
        chk("rst_dz",     64'(bus32.dz_o), 64'd0);
        chk("rst_state",  64'(st32), 64'd0);
        rst = 1'b1;

        // Table-driven directed vectors.
        for (int i = 0; i < 12; i++) begin
            run32(vecs[i].sgn, vecs[i].a, vecs[i].b, res, dz, lat, bsy, got);
            chk($sformatf("v%0d_result", i), res, vecs[i].exp_res);
            chk($sformatf("v%0d_dz", i), 64'(dz), 64'(vecs[i].exp_dz));
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("v%0d_busy_cycles", i), 64'(bsy), vecs[i].exp_dz ? 64'd0 : 64'd32);
            @(negedge clk);
            chk($sformatf("v%0d_ready_pulse", i), 64'(bus32.ready_o), 64'd0);
            chk($sformatf("v%0d_result_hold", i), bus32.result_o, vecs[i].exp_res);
        end

        // Annul in the tenth BUSY cycle, then a fresh operation.
        start_and_annul(32'd1000, 32'd3, 10, vecs[11].exp_res, "annul10");
        run32(1'b0, 32'd9, 32'd3, res, dz, lat, bsy, got);
        chk("after_annul_result",  res, {32'h0, 32'h3});
        chk("after_annul_latency", 64'(lat), 64'd33);

        // An annul in the last BUSY cycle beats the completion.
        start_and_annul(32'd1000, 32'd3, 32, {32'h0, 32'h3}, "annul_last");

        // In IDLE, start together with annul is not accepted.
        @(negedge clk);
        bus32.opdata1_i = 32'd50; bus32.opdata2_i = 32'd5;
        bus32.start_i = 1'b1; bus32.annul_i = 1'b1;
        got = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus32.busy_o || bus32.ready_o) got = 1'b1;
        end
        bus32.start_i = 1'b0; bus32.annul_i = 1'b0;
        chk("idle_annul_blocks", 64'(got), 64'd0);
        chk("idle_annul_result", bus32.result_o, {32'h0, 32'h3});

        // A reset mid-BUSY clears the outputs immediately.
        @(negedge clk);
        bus32.opdata1_i = 32'd1000; bus32.opdata2_i = 32'd3; bus32.start_i = 1'b1;
        @(negedge clk);
        bus32.start_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 64'(bus32.busy_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_result", bus32.result_o, 64'd0);
        chk("mid_rst_busy",   64'(bus32.busy_o), 64'd0);
        chk("mid_rst_ready",  64'(bus32.ready_o), 64'd0);
        chk("mid_rst_dz",     64'(bus32.dz_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run32(1'b0, 32'd64, 32'd8, res, dz, lat, bsy, got);
        chk("post_rst_result",  res, {32'h0, 32'h8});
        chk("post_rst_latency", 64'(lat), 64'd33);

        // The 16-bit, 4-bits-per-cycle instance.
        run16(1'b0, 16'hFFFF, 16'h0010, res16, dz, lat, got);
        chk("w16_ffff_result",  64'(res16), 64'h000F_0FFF);
        chk("w16_ffff_latency", 64'(lat), 64'd5);
        run16(1'b1, 16'h8000, 16'hFFFF, res16, dz, lat, got);
        chk("w16_min_result", 64'(res16), 64'h0000_8000);
        run16(1'b1, 16'd5, 16'd0, res16, dz, lat, got);
        chk("w16_dz_result",  64'(res16), 64'h0005_FFFF);
        chk("w16_dz_flag",    64'(dz), 64'd1);
        chk("w16_dz_latency", 64'(lat), 64'd1);

        for (int i = 0; i < 300; i++) begin
            logic        s;
            logic [15:0] a, b;
            logic [32:0] m;
            s = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 65535));
            b = (i % 25 == 0) ? 16'd0 :
                (i % 7 == 0)  ? 16'($urandom_range(0, 15)) :
                                16'($urandom_range(0, 65535));
            m = model16(s, a, b);
            run16(s, a, b, res16, dz, lat, got);
            chk($sformatf("sweep%0d_result", i), 64'(res16), 64'(m[31:0]));
            chk($sformatf("sweep%0d_dz", i), 64'(dz), 64'(m[32]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
